// File: rtl/strip_alloc_ctrl_pkg.sv
// Shared types and constants for the strip allocation controller.
// Holds the FSM state encoding, height limits and the height-to-ROM address map.
package strip_alloc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_RESP
  } state_t;

  localparam int unsigned HMIN_DEFAULT = 4;
  localparam int unsigned HMAX_DEFAULT = 16;

  // Heights at or above this value share the last ROM entry.
  localparam logic [4:0] COLLAPSE_HEIGHT = 5'd13;
  localparam logic [3:0] COLLAPSE_ADDR   = 4'd9;
  localparam logic [4:0] MAP_BASE        = 5'd4;

  function automatic logic [3:0] height_to_addr(input logic [4:0] h);
    logic [4:0] off;
    off = h - MAP_BASE;
    if (h >= COLLAPSE_HEIGHT) return COLLAPSE_ADDR;
    return off[3:0];
  endfunction

endpackage

// File: rtl/rom_strip_id.sv
// Strip-ID ROM: three candidate IDs per address, registered on en.
// Output holds its last value while en is low.
module rom_strip_id (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] addr,
  output logic [3:0] id1,
  output logic [3:0] id2,
  output logic [3:0] id3
);

  logic [11:0] word;

  always_comb begin
    word = '0;
    case (addr)
      4'd0:    word = {4'hA, 4'h8, 4'h0};
      4'd1:    word = {4'h8, 4'h6, 4'h0};
      4'd2:    word = {4'h6, 4'h4, 4'h0};
      4'd3:    word = {4'h4, 4'h1, 4'h2};
      4'd4:    word = {4'h1, 4'h2, 4'h3};
      4'd5:    word = {4'h3, 4'h5, 4'h0};
      4'd6:    word = {4'h5, 4'h7, 4'h0};
      4'd7:    word = {4'h7, 4'h9, 4'h0};
      4'd8:    word = {4'h9, 4'h0, 4'h0};
      4'd9:    word = {4'hB, 4'hC, 4'hD};
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id1 <= '0;
      id2 <= '0;
      id3 <= '0;
    end else if (en) begin
      {id1, id2, id3} <= word;
    end
  end

endmodule

// File: rtl/strip_alloc_ctrl.sv
// Strip allocation controller: validates a height, looks up candidate strip IDs
// in the ROM, grants the first free one and tracks occupancy with releases.
module strip_alloc_ctrl
  import strip_alloc_ctrl_pkg::*;
#(
  parameter int unsigned HMIN = HMIN_DEFAULT,
  parameter int unsigned HMAX = HMAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [4:0]  req_height,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_ok,
  output logic        resp_err,
  output logic [3:0]  resp_id,
  input  logic        rel_valid,
  input  logic [3:0]  rel_id,
  output logic [15:0] busy_map,
  output logic [3:0]  free_count
);

  localparam logic [4:0] HMIN_H = 5'(HMIN);
  localparam logic [4:0] HMAX_H = 5'(HMAX);

  state_t      state, state_next;
  logic [4:0]  height;
  logic        rom_en;
  logic [3:0]  rom_id1, rom_id2, rom_id3;

  logic        accept, load_resp, set_valid, clr_valid;
  logic        ok_next, err_next;
  logic [3:0]  id_next;
  logic [15:0] grant_mask, rel_mask, busy_next;
  logic [3:0]  free_next;

  rom_strip_id u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rom_en),
    .addr  (height_to_addr(height)),
    .id1   (rom_id1),
    .id2   (rom_id2),
    .id3   (rom_id3)
  );

  assign req_ready = (state == ST_IDLE);
  assign rom_en    = (state == ST_LOOKUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_resp  = 1'b0;
    set_valid  = 1'b0;
    clr_valid  = 1'b0;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    id_next    = '0;
    grant_mask = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_height >= HMIN_H && req_height <= HMAX_H) begin
            state_next = ST_LOOKUP;
          end else begin
            state_next = ST_RESP;
            load_resp  = 1'b1;
            err_next   = 1'b1;
          end
        end
      end
      ST_LOOKUP: state_next = ST_CHECK;
      ST_CHECK: begin
        // Grant sees the registered map, so a same-cycle release is not visible.
        load_resp  = 1'b1;
        state_next = ST_RESP;
        if (rom_id1 != 4'd0 && !busy_map[rom_id1])      id_next = rom_id1;
        else if (rom_id2 != 4'd0 && !busy_map[rom_id2]) id_next = rom_id2;
        else if (rom_id3 != 4'd0 && !busy_map[rom_id3]) id_next = rom_id3;
        if (id_next != 4'd0) begin
          ok_next    = 1'b1;
          grant_mask = 16'b1 << id_next;
        end
      end
      ST_RESP: begin
        // resp_valid rises one edge after entering RESP; consume only once it is up.
        if (!resp_valid) begin
          set_valid = 1'b1;
        end else if (resp_ready) begin
          clr_valid  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rel_mask = '0;
    if (rel_valid && rel_id != 4'd0) rel_mask = 16'b1 << rel_id;
    busy_next = (busy_map & ~rel_mask) | grant_mask;
    free_next = '0;
    for (int unsigned i = 1; i < 16; i++) free_next = free_next + {3'b000, ~busy_next[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_map   <= '0;
      free_count <= 4'd15;
    end else begin
      busy_map   <= busy_next;
      free_count <= free_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) height <= '0;
    else if (accept) height <= req_height;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_err   <= 1'b0;
      resp_id    <= '0;
    end else begin
      if (load_resp) begin
        resp_ok  <= ok_next;
        resp_err <= err_next;
        resp_id  <= id_next;
      end
      if (set_valid)      resp_valid <= 1'b1;
      else if (clr_valid) resp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/strip_alloc_ctrl.md
STRIP_ALLOC_CTRL -- requirements
Module: strip_alloc_ctrl

Interface
REQ-001 SHALL have parameter HMIN, default 4, meaning the smallest legal height.
REQ-002 SHALL have parameter HMAX, default 16, meaning the largest legal height.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1, meaning an allocation request is present.
REQ-006 SHALL have port req_height, input, 5, meaning the requested height.
REQ-007 SHALL have port req_ready, output, 1, meaning the controller accepts a request; high only in IDLE.
REQ-008 SHALL have port resp_valid, output, 1, meaning a response is held on resp_*.
REQ-009 SHALL have port resp_ready, input, 1, meaning the requester consumes the response.
REQ-010 SHALL have port resp_ok, output, 1, meaning a strip was granted.
REQ-011 SHALL have port resp_err, output, 1, meaning the height was illegal.
REQ-012 SHALL have port resp_id, output, 4, meaning the granted strip ID, 0 when not granted.
REQ-013 SHALL have port rel_valid, input, 1, meaning a one-cycle release strobe.
REQ-014 SHALL have port rel_id, input, 4, meaning the strip ID to free.
REQ-015 SHALL have port busy_map, output, 16, meaning the strip occupancy; bit n set means ID n is allocated, and bit 0 is always 0.
REQ-016 SHALL have port free_count, output, 4, meaning the number of clear bits among IDs 1..15, saturating at 15.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, CHECK and RESP.
REQ-018 On req_valid&&req_ready in IDLE at edge T: latch height; legal (HMIN..HMAX) -> LOOKUP; illegal -> RESP with ok=0, err=1, id=0, resp_valid high after edge T+1.
REQ-019 Address map: height 4..12 -> addr=height-4; 13..16 -> addr 9.
REQ-020 LOOKUP SHALL drive ROM en=1 and the latched addr for exactly one cycle, then -> CHECK; ROM en=0 in all other states.
REQ-021 CHECK: grant the first of Id1, Id2, Id3 (priority order) that is nonzero and has a clear busy bit; set that busy bit, ok=1, id=grant; if none qualifies, ok=0, err=0, id=0; -> RESP.
REQ-022 Legal-request latency: resp_valid SHALL be high after edge T+3.
REQ-023 RESP SHALL hold resp_* stable while resp_ready=0; on resp_ready=1, -> IDLE and deassert resp_valid at the next edge.
REQ-024 Release SHALL be accepted in any state: rel_valid with rel_id!=0 clears busy bit rel_id at the next edge; a release of an ID that is already free, or of ID 0, is ignored.
REQ-025 CHECK SHALL evaluate the registered busy_map from before the current-edge release, so a release in the CHECK cycle is not visible to that grant.
REQ-026 Busy update: busy_next = (busy & ~rel_mask) | grant_mask; a release and a grant of the same ID in one cycle leave the bit set.
REQ-027 free_count SHALL be registered and consistent with busy_map in the same cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, busy_map=0, free_count=15, resp_valid=0, resp_ok=0, resp_err=0, resp_id=0, and ROM en=0.
REQ-029 A reset mid-operation SHALL abandon the in-flight request with no response, and req_ready SHALL be high on the first edge after deassertion.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the HMIN/HMAX defaults, and the 13->9 height-collapse constant.
REQ-031 SHALL instantiate exactly one sub-module, the existing strip-ID ROM rom_strip_id; all other logic is local.
REQ-032 ROM contents by addr (Id1,Id2,Id3): 0:A,8,0; 1:8,6,0; 2:6,4,0; 3:4,1,2; 4:1,2,3; 5:3,5,0; 6:5,7,0; 7:7,9,0; 8:9,0,0; 9:B,C,D.

Verification
REQ-033 After reset, three requests with height=4 -> ok/id = 1/A, then 1/8, then ok=0, err=0, id=0; busy_map=0x0500; free_count=13.
REQ-034 Height=3 or height=17 -> resp_err=1, id=0, resp_valid after T+1, busy_map unchanged.
REQ-035 Height=12 -> id 9; height=12 again -> fail; rel_id=9 pulse; height=12 -> id 9.
REQ-036 Heights 13, 14, 15, 16 -> ids B, C, D, then fail; rel_id=0 and a release of free ID 5 -> no change.
REQ-037 Hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout; a rel_valid for the grant ID issued during CHECK -> bit remains set.
REQ-038 rst_n pulsed low during LOOKUP -> no response, busy_map=0, and a new height=8 request -> id 1.
